// File: rtl/rca_seq_adder_pkg.sv
// rtl/rca_seq_adder_pkg.sv - shared constants, FSM state encoding and sizing helpers for rca_seq_adder
package rca_seq_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

    // Counter is at least one bit wide so the smallest legal WIDTH still elaborates.
    function automatic int cnt_w(input int width);
        return (nslice(width) > 1) ? $clog2(nslice(width)) : 1;
    endfunction

endpackage

// File: rtl/rca_slice4.sv
// rtl/rca_slice4.sv - combinational 4-bit ripple-carry slice built from full-adder cells
module rca_slice4
    import rca_seq_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE_W];

endmodule

// File: rtl/rca_seq_adder.sv
// rtl/rca_seq_adder.sv - nibble-serial WIDTH-bit adder on one shared slice; SEQ_ADD_SUB_EN adds subtract
module rca_seq_adder
    import rca_seq_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
`ifdef SEQ_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int CW     = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]         state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic               cout_q;
    logic [CW-1:0]      idx;
    logic [SLICE_W-1:0] sum_n [NSLICE];

    logic [SLICE_W-1:0] a_nib [NSLICE];
    logic [SLICE_W-1:0] b_nib [NSLICE];
    logic [SLICE_W-1:0] s_a;
    logic [SLICE_W-1:0] s_b;
    logic [SLICE_W-1:0] s_sum;
    logic               s_cout;
    logic               sub_sel;

`ifdef SEQ_ADD_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    for (genvar g = 0; g < NSLICE; g++) begin : g_nib
        assign a_nib[g]                       = a_q[g*SLICE_W +: SLICE_W];
        assign b_nib[g]                       = b_q[g*SLICE_W +: SLICE_W];
        assign sum[g*SLICE_W +: SLICE_W]      = sum_n[g];
    end

    assign s_a = a_nib[idx];
    assign s_b = b_nib[idx];

    rca_slice4 u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            for (int i = 0; i < NSLICE; i++) begin
                sum_n[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1, so the forced carry-in replaces cin.
                        a_q     <= in1;
                        b_q     <= sub_sel ? ~in2 : in2;
                        carry_q <= sub_sel | cin;
                        idx     <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_n[idx] <= s_sum;
                    carry_q    <= s_cout;
                    if (idx == LAST) begin
                        cout_q <= s_cout;
                        idx    <= '0;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign cout      = cout_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// tb/tb_rca_seq_adder.sv - randomized self-checking bench for rca_seq_adder against an arithmetic model
module tb_rca_seq_adder;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             cin       = 1'b0;
    logic             sub       = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in1       = '0;
    logic [WIDTH-1:0] in2       = '0;
    logic             in_ready;
    logic             out_valid;
    logic             cout;
    logic [WIDTH-1:0] sum;

    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    logic ov_prev  = 1'b0;
    logic chk_idle = 1'b0;
    logic [WIDTH:0] exp_q[$];

    rca_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
`ifdef SEQ_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c, input logic s);
        if (s)
            return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
    endfunction

    // Single compare process: predicts at acceptance, checks every DONE cycle.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (!rst_n) begin
            exp_q.delete();
            chk_idle = 1'b0;
            ov_prev  = 1'b0;
        end else begin
            if (chk_idle) begin
                check("post_handshake_in_ready", in_ready, 1);
                check("post_handshake_out_valid", out_valid, 0);
                chk_idle = 1'b0;
            end
            check("ready_valid_exclusive", in_ready & out_valid, 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in1, in2, cin, sub));
                acc_cyc = cyc + 1;
            end
            if (out_valid) begin
                check("pending_results", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    if (!ov_prev)
                        check("latency", cyc - acc_cyc, NSLICE);
                    check("sum", sum, e[WIDTH-1:0]);
                    check("cout", cout, e[WIDTH]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        chk_idle = 1'b1;
                    end
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                          input logic s, input int hold, input bit lit,
                          input logic [WIDTH-1:0] es, input logic ec);
        int n;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in1       = a;
        in2       = b;
        cin       = c;
        sub       = s;
        out_ready = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            in1 = WIDTH'($urandom);
            in2 = WIDTH'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
            n++;
        end
        check("result_wait", out_valid, 1);
        if (lit) begin
            check("lit_sum", sum, es);
            check("lit_cout", cout, ec);
        end
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            if (lit) begin
                check("lit_sum_held", sum, es);
                check("lit_valid_held", out_valid, 1);
                check("lit_in_ready_held", in_ready, 0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic s;
        check("model_add", model(16'h1234, 16'h0FFF, 1'b0, 1'b0), 17'h02233);
        check("model_carry", model(16'hFFFF, 16'h0001, 1'b0, 1'b0), 17'h10000);
        check("model_cin", model(16'h0000, 16'h0000, 1'b1, 1'b0), 17'h00001);
        check("model_sub_borrow", model(16'h0005, 16'h0007, 1'b0, 1'b1), 17'h0FFFE);
        check("model_sub_noborrow", model(16'h0007, 16'h0005, 1'b0, 1'b1), 17'h10002);

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 3, 1'b1, 16'h2233, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h0000, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1, 1'b1, 16'h0001, 1'b0);

        // Abort mid-RUN with idx at 2.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in1      = 16'h1234;
        in2      = 16'h0FFF;
        cin      = 1'b0;
        sub      = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h0002, 1'b0);

`ifdef SEQ_ADD_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b1, 16'hFFFE, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 2, 1'b1, 16'h0002, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef SEQ_ADD_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), s,
                   int'($urandom_range(0, 3)), 1'b0, '0, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
